instruction_fetch: RTL and testbench

//  MIPS pipeline IF stage: holds the PC and a loadable instruction memory.

---
 rtl/instruction_fetch_pkg.sv | 25 ++
 rtl/instruction_memory.sv | 69 ++++++
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage.
//   PC_SIZE_DEFAULT            default PC / instruction / address width
//   WORD_SIZE_IN_BYTES_DEFAULT default instruction size in bytes (PC step)
//   MEM_SIZE_IN_WORDS_DEFAULT  default instruction memory depth
//   NOP                        all-zero instruction word
//   pc_src_e                   next-PC source select
//   addr_width()               index width for a memory of a given depth
package instruction_fetch_pkg;

  localparam int unsigned PC_SIZE_DEFAULT            = 32;
  localparam int unsigned WORD_SIZE_IN_BYTES_DEFAULT = 4;
  localparam int unsigned MEM_SIZE_IN_WORDS_DEFAULT  = 10;

  localparam logic [PC_SIZE_DEFAULT-1:0] NOP = 32'h0;

  typedef enum logic {
    PC_SRC_SEQ     = 1'b0,
    PC_SRC_NOT_SEQ = 1'b1
  } pc_src_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Loadable instruction memory for the fetch stage.
// A loader appends words sequentially through the write port; the fetch side
// reads one word combinationally by word index.
// Configuration macro: IF_FETCH_BOUNDS_CHECK_EN
//   defined   -> index >= MEM_SIZE_IN_WORDS reads as NOP
//   undefined -> index wraps modulo MEM_SIZE_IN_WORDS
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous active-high reset (clears words and pointer)
//   i_write_mem  append i_data at the loader pointer (ignored when full)
//   i_clear_mem  clear all words and the loader pointer (beats write)
//   i_data       loader data word
//   i_word_index fetch word index
//   o_data       word at i_word_index (combinational)
//   o_full_mem   loader pointer == MEM_SIZE_IN_WORDS
//   o_empty_mem  loader pointer == 0
module instruction_memory
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned PC_SIZE           = PC_SIZE_DEFAULT,
  parameter int unsigned MEM_SIZE_IN_WORDS = MEM_SIZE_IN_WORDS_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_write_mem,
  input  logic               i_clear_mem,
  input  logic [PC_SIZE-1:0] i_data,
  input  logic [PC_SIZE-1:0] i_word_index,
  output logic [PC_SIZE-1:0] o_data,
  output logic               o_full_mem,
  output logic               o_empty_mem
);

  localparam int unsigned ADDR_W = addr_width(MEM_SIZE_IN_WORDS);
  localparam int unsigned PTR_W  = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic [PC_SIZE-1:0] mem [MEM_SIZE_IN_WORDS];
  logic [PTR_W-1:0]   ptr;

  assign o_full_mem  = (ptr == PTR_W'(MEM_SIZE_IN_WORDS));
  assign o_empty_mem = (ptr == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear_mem) begin
      for (int unsigned i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
        mem[i] <= '0;
      end
      ptr <= '0;
    end else if (i_write_mem && !o_full_mem) begin
      mem[ADDR_W'(ptr)] <= i_data;
      ptr               <= ptr + PTR_W'(1);
    end
  end

`ifdef IF_FETCH_BOUNDS_CHECK_EN
  always_comb begin
    o_data = PC_SIZE'(NOP);
    if (i_word_index < PC_SIZE'(MEM_SIZE_IN_WORDS)) begin
      o_data = mem[ADDR_W'(i_word_index)];
    end
  end
`else
  // Wrap keeps every PC mapped onto a real word without a range check.
  always_comb begin
    o_data = mem[ADDR_W'(i_word_index % PC_SIZE'(MEM_SIZE_IN_WORDS))];
  end
`endif

endmodule

// File: rtl/instruction_fetch.sv
// MIPS pipeline IF stage: PC register, next-PC select, PC adder, flush mux and
// a loadable instruction memory.
// Configuration macro: IF_FETCH_BOUNDS_CHECK_EN (see instruction_memory).
// Ports:
//   i_clk              clock, rising edge
//   i_reset            synchronous active-high reset
//   i_halt             1 = freeze PC
//   i_not_load         1 = hazard stall, PC not loaded
//   i_enable           1 = stage runs
//   i_next_pc_src      0 = i_next_seq_pc, 1 = i_next_not_seq_pc
//   i_write_mem        append i_instruction to memory
//   i_clear_mem        clear memory and loader pointer
//   i_flush            output NOP instead of fetched word
//   i_instruction      loader data word
//   i_next_not_seq_pc  branch/jump target
//   i_next_seq_pc      sequential next PC fed back from the pipeline
//   o_full_mem         memory full
//   o_empty_mem        memory empty
//   o_instruction      word at PC (combinational)
//   o_next_seq_pc      PC + WORD_SIZE_IN_BYTES (combinational)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned PC_SIZE            = PC_SIZE_DEFAULT,
  parameter int unsigned WORD_SIZE_IN_BYTES = WORD_SIZE_IN_BYTES_DEFAULT,
  parameter int unsigned MEM_SIZE_IN_WORDS  = MEM_SIZE_IN_WORDS_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_not_load,
  input  logic               i_enable,
  input  logic               i_next_pc_src,
  input  logic               i_write_mem,
  input  logic               i_clear_mem,
  input  logic               i_flush,
  input  logic [PC_SIZE-1:0] i_instruction,
  input  logic [PC_SIZE-1:0] i_next_not_seq_pc,
  input  logic [PC_SIZE-1:0] i_next_seq_pc,
  output logic               o_full_mem,
  output logic               o_empty_mem,
  output logic [PC_SIZE-1:0] o_instruction,
  output logic [PC_SIZE-1:0] o_next_seq_pc
);

  logic [PC_SIZE-1:0] pc;
  logic [PC_SIZE-1:0] next_pc;
  logic [PC_SIZE-1:0] word_index;
  logic [PC_SIZE-1:0] fetched;
  logic               pc_load;
  pc_src_e            pc_src;

  assign pc_src  = pc_src_e'(i_next_pc_src);
  assign pc_load = i_enable && !i_halt && !i_not_load;

  always_comb begin
    next_pc = i_next_seq_pc;
    if (pc_src == PC_SRC_NOT_SEQ) begin
      next_pc = i_next_not_seq_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc <= '0;
    end else if (pc_load) begin
      pc <= next_pc;
    end
  end

  // Division drops the byte-offset bits of the PC.
  assign word_index    = pc / PC_SIZE'(WORD_SIZE_IN_BYTES);
  assign o_next_seq_pc = pc + PC_SIZE'(WORD_SIZE_IN_BYTES);

  always_comb begin
    o_instruction = fetched;
    if (i_flush) begin
      o_instruction = PC_SIZE'(NOP);
    end
  end

  instruction_memory #(
    .PC_SIZE           (PC_SIZE),
    .MEM_SIZE_IN_WORDS (MEM_SIZE_IN_WORDS)
  ) u_instruction_memory (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_write_mem  (i_write_mem),
    .i_clear_mem  (i_clear_mem),
    .i_data       (i_instruction),
    .i_word_index (word_index),
    .o_data       (fetched),
    .o_full_mem   (o_full_mem),
    .o_empty_mem  (o_empty_mem)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a 40-word memory.
// Reference model: an array of words, a loader count and a PC value updated
// once per clock from the input rules; outputs derived with plain arithmetic.
module tb_instruction_fetch;

  localparam int unsigned MEM = 40;

  logic        i_clk = 1'b0;
  logic        i_reset, i_halt, i_not_load, i_enable, i_next_pc_src;
  logic        i_write_mem, i_clear_mem, i_flush;
  logic [31:0] i_instruction, i_next_not_seq_pc, i_next_seq_pc;
  logic        o_full_mem, o_empty_mem;
  logic [31:0] o_instruction, o_next_seq_pc;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] m_mem [MEM];
  int unsigned m_ptr;
  logic [31:0] m_pc;

  instruction_fetch #(
    .PC_SIZE            (32),
    .WORD_SIZE_IN_BYTES (4),
    .MEM_SIZE_IN_WORDS  (MEM)
  ) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_halt            (i_halt),
    .i_not_load        (i_not_load),
    .i_enable          (i_enable),
    .i_next_pc_src     (i_next_pc_src),
    .i_write_mem       (i_write_mem),
    .i_clear_mem       (i_clear_mem),
    .i_flush           (i_flush),
    .i_instruction     (i_instruction),
    .i_next_not_seq_pc (i_next_not_seq_pc),
    .i_next_seq_pc     (i_next_seq_pc),
    .o_full_mem        (o_full_mem),
    .o_empty_mem       (o_empty_mem),
    .o_instruction     (o_instruction),
    .o_next_seq_pc     (o_next_seq_pc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] exp_instr();
    logic [31:0] idx;
    idx = m_pc / 4;
    if (i_flush) return 32'h0;
`ifdef IF_FETCH_BOUNDS_CHECK_EN
    if (idx >= MEM) return 32'h0;
    return m_mem[idx];
`else
    return m_mem[idx % MEM];
`endif
  endfunction

  // Advance one clock and apply the same clock to the model, then settle.
  task automatic tick();
    @(posedge i_clk);
    if (i_reset) begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      m_ptr = 0;
      m_pc  = 32'h0;
    end else begin
      if (i_clear_mem) begin
        foreach (m_mem[i]) m_mem[i] = 32'h0;
        m_ptr = 0;
      end else if (i_write_mem && m_ptr < MEM) begin
        m_mem[m_ptr] = i_instruction;
        m_ptr++;
      end
      if (i_enable && !i_halt && !i_not_load)
        m_pc = i_next_pc_src ? i_next_not_seq_pc : i_next_seq_pc;
    end
    #1;
  endtask

  task automatic idle();
    i_reset = 0; i_halt = 0; i_not_load = 0; i_enable = 0; i_next_pc_src = 0;
    i_write_mem = 0; i_clear_mem = 0; i_flush = 0;
    i_instruction = 0; i_next_not_seq_pc = 0; i_next_seq_pc = 0;
  endtask

  task automatic jump_to(input logic [31:0] target);
    i_enable = 1; i_halt = 0; i_not_load = 0;
    i_next_pc_src = 1; i_next_not_seq_pc = target;
    tick();
    i_next_pc_src = 0; i_enable = 0;
  endtask

  task automatic test_reset();
    idle();
    i_reset = 1; i_write_mem = 1; i_instruction = 32'hDEADBEEF;
    i_enable = 1; i_next_seq_pc = 32'h40;
    tick(); tick();
    idle();
    vectors++;
    if (o_empty_mem !== 1'b1) begin miscompares++;
      $display("FAIL reset_empty: got %b expected 1", o_empty_mem); end
    vectors++;
    if (o_full_mem !== 1'b0) begin miscompares++;
      $display("FAIL reset_full: got %b expected 0", o_full_mem); end
    vectors++;
    if (o_instruction !== 32'h0) begin miscompares++;
      $display("FAIL reset_instr: got %h expected 00000000", o_instruction); end
    vectors++;
    if (o_next_seq_pc !== 32'h4) begin miscompares++;
      $display("FAIL reset_next_pc: got %h expected 00000004", o_next_seq_pc); end
  endtask

  task automatic test_load();
    idle();
    for (int k = 0; k < MEM; k++) begin
      i_write_mem = 1; i_instruction = $urandom;
      tick();
      vectors++;
      if (o_full_mem !== (k == MEM - 1)) begin miscompares++;
        $display("FAIL load_full[%0d]: got %b expected %b", k, o_full_mem, k == MEM - 1); end
      vectors++;
      if (o_empty_mem !== 1'b0) begin miscompares++;
        $display("FAIL load_empty[%0d]: got %b expected 0", k, o_empty_mem); end
      if (k == 0) begin
        vectors++;
        if (o_instruction !== m_mem[0]) begin miscompares++;
          $display("FAIL load_readback: got %h expected %h", o_instruction, m_mem[0]); end
      end
    end
    i_instruction = 32'hFFFFFFFF;
    tick();
    i_write_mem = 0;
    vectors++;
    if (o_full_mem !== 1'b1) begin miscompares++;
      $display("FAIL load_overflow_full: got %b expected 1", o_full_mem); end
    jump_to(32'd156);
    vectors++;
    if (o_instruction !== m_mem[39] || o_instruction === 32'hFFFFFFFF) begin miscompares++;
      $display("FAIL load_mem39: got %h expected %h", o_instruction, m_mem[39]); end
  endtask

  task automatic test_run();
    idle();
    jump_to(32'h0);
    i_enable = 1;
    for (int k = 0; k < MEM; k++) begin
      vectors++;
      if (o_instruction !== m_mem[k]) begin miscompares++;
        $display("FAIL run_instr[%0d]: got %h expected %h", k, o_instruction, m_mem[k]); end
      vectors++;
      if (o_next_seq_pc !== 32'(k * 4 + 4)) begin miscompares++;
        $display("FAIL run_next_pc[%0d]: got %h expected %h", k, o_next_seq_pc, k * 4 + 4); end
      i_next_seq_pc = 32'(k * 4 + 4);
      tick();
    end
    i_enable = 0;
  endtask

  task automatic test_stall();
    logic [31:0] frozen_next, frozen_instr;
    idle();
    jump_to(32'd8);
    for (int mode = 0; mode < 3; mode++) begin
      i_enable = (mode != 0); i_halt = (mode == 1); i_not_load = (mode == 2);
      frozen_next = o_next_seq_pc; frozen_instr = o_instruction;
      i_next_seq_pc = 32'd12;
      for (int c = 0; c < 4; c++) begin
        i_next_seq_pc += 4;
        i_next_not_seq_pc = $urandom; i_next_pc_src = c[0];
        tick();
        vectors++;
        if (o_next_seq_pc !== frozen_next || o_instruction !== frozen_instr) begin miscompares++;
          $display("FAIL stall_mode%0d: got pc+4=%h instr=%h expected %h %h",
                   mode, o_next_seq_pc, o_instruction, frozen_next, frozen_instr); end
      end
      i_enable = 1; i_halt = 0; i_not_load = 0; i_next_pc_src = 0;
      tick();
      vectors++;
      if (o_next_seq_pc !== i_next_seq_pc + 4 || o_instruction !== exp_instr()) begin miscompares++;
        $display("FAIL stall_resume%0d: got pc+4=%h instr=%h expected %h %h",
                 mode, o_next_seq_pc, o_instruction, i_next_seq_pc + 4, exp_instr()); end
      i_enable = 0;
    end
  endtask

  task automatic test_branch();
    idle();
    jump_to(32'd100);
    i_enable = 1; i_next_seq_pc = 32'd104;
    i_next_pc_src = 1; i_next_not_seq_pc = 32'd20;
    tick();
    i_next_pc_src = 0; i_enable = 0;
    vectors++;
    if (o_instruction !== m_mem[5]) begin miscompares++;
      $display("FAIL branch_instr: got %h expected %h", o_instruction, m_mem[5]); end
    vectors++;
    if (o_next_seq_pc !== 32'd24) begin miscompares++;
      $display("FAIL branch_next_pc: got %h expected %h", o_next_seq_pc, 32'd24); end
  endtask

  task automatic test_flush_bounds();
    logic [31:0] exp_far;
    idle();
    jump_to(32'd160);
`ifdef IF_FETCH_BOUNDS_CHECK_EN
    exp_far = 32'h0;
`else
    exp_far = m_mem[0];
`endif
    vectors++;
    if (o_instruction !== exp_far) begin miscompares++;
      $display("FAIL bounds_pc160: got %h expected %h", o_instruction, exp_far); end
    jump_to(32'd12);
    i_flush = 1; #1;
    vectors++;
    if (o_instruction !== 32'h0) begin miscompares++;
      $display("FAIL flush_nop: got %h expected 00000000", o_instruction); end
    i_flush = 0; #1;
    vectors++;
    if (o_instruction !== m_mem[3]) begin miscompares++;
      $display("FAIL flush_release: got %h expected %h", o_instruction, m_mem[3]); end
    jump_to(32'hFFFFFFFC);
    vectors++;
    if (o_next_seq_pc !== 32'h0) begin miscompares++;
      $display("FAIL adder_wrap: got %h expected 00000000", o_next_seq_pc); end
    vectors++;
    if (o_instruction !== exp_instr()) begin miscompares++;
      $display("FAIL top_pc_fetch: got %h expected %h", o_instruction, exp_instr()); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    idle();
    for (int c = 0; c < 300; c++) begin
      i_enable = ($urandom_range(0, 3) != 0);
      i_halt = ($urandom_range(0, 5) == 0);
      i_not_load = ($urandom_range(0, 5) == 0);
      i_next_pc_src = $urandom_range(0, 1);
      i_flush = ($urandom_range(0, 7) == 0);
      t = $urandom;
      i_next_not_seq_pc = ($urandom_range(0, 7) == 0) ? t : 32'($urandom_range(0, MEM * 8 - 1));
      i_next_seq_pc = m_pc + 4;
      tick();
      vectors++;
      if (o_instruction !== exp_instr() || o_next_seq_pc !== m_pc + 4) begin miscompares++;
        $display("FAIL random[%0d]: got instr=%h pc+4=%h expected %h %h",
                 c, o_instruction, o_next_seq_pc, exp_instr(), m_pc + 4); end
    end
    idle();
  endtask

  task automatic test_clear();
    logic [31:0] before_next;
    idle();
    jump_to(32'd28);
    before_next = o_next_seq_pc;
    i_clear_mem = 1; i_write_mem = 1; i_instruction = 32'h12345678;
    tick();
    i_clear_mem = 0; i_write_mem = 0;
    vectors++;
    if (o_empty_mem !== 1'b1 || o_full_mem !== 1'b0) begin miscompares++;
      $display("FAIL clear_flags: got empty=%b full=%b expected 1 0", o_empty_mem, o_full_mem); end
    vectors++;
    if (o_next_seq_pc !== before_next) begin miscompares++;
      $display("FAIL clear_pc_kept: got %h expected %h", o_next_seq_pc, before_next); end
    for (int k = 0; k < 6; k++) begin
      jump_to(32'($urandom_range(0, MEM * 8 - 1)));
      vectors++;
      if (o_instruction !== 32'h0) begin miscompares++;
        $display("FAIL clear_instr[%0d]: got %h expected 00000000", k, o_instruction); end
    end
    jump_to(32'h0);
    i_write_mem = 1; i_instruction = 32'hCAFEF00D;
    tick();
    i_write_mem = 0;
    vectors++;
    if (o_empty_mem !== 1'b0 || o_instruction !== 32'hCAFEF00D) begin miscompares++;
      $display("FAIL clear_reload: got empty=%b instr=%h expected 0 cafef00d",
               o_empty_mem, o_instruction); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load();
    test_run();
    test_stall();
    test_branch();
    test_flush_bounds();
    test_random();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
